// File: rtl/i2s_tx_master.sv
// Master-mode I2S transmitter: one free-running divider makes MCLK/BCK/LRCK and a
// one-frame holding register feeds Philips-format 32-bit slots toward the DAC.
module i2s_tx_master #(
  parameter int DATA_WIDTH    = 16,
  parameter int MCLK_DIV_LOG2 = 2,
  parameter int BCK_DIV_LOG2  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  underrun_clr,
  output logic                  i2s_mclk,
  output logic                  i2s_bck,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  underrun_pulse,
  output logic [7:0]            underrun_count
);
  localparam int W = BCK_DIV_LOG2 + 6;
  localparam logic [5:0] DW = 6'(DATA_WIDTH);

  logic [W-1:0]          cnt;
  logic [W-1:0]          cnt_nxt;
  logic                  bck_fall;
  logic                  frame_end;
  logic [4:0]            next_k;
  logic                  next_right;
  logic                  data_bit;
  logic                  full;
  logic                  accept;
  logic                  underrun;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [DATA_WIDTH-1:0] sh_left;
  logic [DATA_WIDTH-1:0] sh_right;

  assign cnt_nxt    = cnt + 1'b1;
  assign bck_fall   = &cnt[BCK_DIV_LOG2-1:0];
  assign frame_end  = &cnt;
  // Slot position and channel as they will be after the coming edge.
  assign next_k     = cnt_nxt[W-2:BCK_DIV_LOG2];
  assign next_right = cnt_nxt[W-1];
  assign data_bit   = (next_k != 5'd0) && ({1'b0, next_k} <= DW);

  assign i2s_mclk = cnt[MCLK_DIV_LOG2-1];
  assign i2s_bck  = cnt[BCK_DIV_LOG2-1];
  assign i2s_lrck = cnt[W-1];

  // Handshake: a frame transfers on any cycle with in_valid && in_ready; in_ready is
  // simply "holding register empty" and never depends on in_valid.
  assign in_ready = !full;
  assign accept   = in_valid && !full;
  assign underrun = frame_end && !full;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt            <= '0;
      full           <= 1'b0;
      hold_left      <= '0;
      hold_right     <= '0;
      sh_left        <= '0;
      sh_right       <= '0;
      i2s_sdata      <= 1'b0;
      underrun_pulse <= 1'b0;
      underrun_count <= 8'd0;
    end else begin
      cnt            <= cnt_nxt;
      underrun_pulse <= underrun;

      // The boundary sees full as it was before this cycle, so a same-cycle accept
      // is kept for the following frame.
      if (frame_end && full) begin
        full <= 1'b0;
      end else if (accept) begin
        full <= 1'b1;
      end
      if (accept) begin
        hold_left  <= in_left;
        hold_right <= in_right;
      end

      if (frame_end) begin
        sh_left  <= full ? hold_left  : '0;
        sh_right <= full ? hold_right : '0;
      end else if (bck_fall && data_bit) begin
        if (next_right) begin
          sh_right <= {sh_right[DATA_WIDTH-2:0], 1'b0};
        end else begin
          sh_left <= {sh_left[DATA_WIDTH-2:0], 1'b0};
        end
      end

      if (bck_fall) begin
        i2s_sdata <= data_bit && (next_right ? sh_right[DATA_WIDTH-1] : sh_left[DATA_WIDTH-1]);
      end

      if (underrun_clr) begin
        underrun_count <= underrun ? 8'd1 : 8'd0;
      end else if (underrun && underrun_count != 8'hFF) begin
        underrun_count <= underrun_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: scoreboard of expected serial frames plus directed checks of
// reset, handshake, underrun counting, boundary collision and clock ratios.
module tb_i2s_tx_master;
  logic        sys_clk;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        underrun_clr;
  logic        i2s_mclk;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        underrun_pulse;
  logic [7:0]  underrun_count;

  // Second instance with 256-cycle frames, used only for counter saturation.
  logic        sys_rst_b;
  logic        b_clr;
  logic        b_ready;
  logic        b_mclk;
  logic        b_bck;
  logic        b_lrck;
  logic        b_sdata;
  logic        b_pulse;
  logic [7:0]  b_count;

  i2s_tx_master dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .underrun_clr(underrun_clr),
    .i2s_mclk(i2s_mclk), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .underrun_pulse(underrun_pulse), .underrun_count(underrun_count)
  );

  i2s_tx_master #(.DATA_WIDTH(16), .MCLK_DIV_LOG2(1), .BCK_DIV_LOG2(2)) dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst_b), .in_valid(1'b0), .in_ready(b_ready),
    .in_left(16'h0000), .in_right(16'h0000), .underrun_clr(b_clr),
    .i2s_mclk(b_mclk), .i2s_bck(b_bck), .i2s_lrck(b_lrck), .i2s_sdata(b_sdata),
    .underrun_pulse(b_pulse), .underrun_count(b_count)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int         cyc = 0;
  logic [9:0] ref_cnt;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) ref_cnt <= '0;
    else         ref_cnt <= ref_cnt + 10'd1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [63:0] exp_q[$];
  logic [63:0] cur_frame;
  logic [63:0] obs_frame = '0;
  logic        exp_pulse;
  logic [7:0]  exp_count;
  logic        prev_bck, prev_lrck, prev_sdata;
  logic        full_old, m_underrun;
  int clk_bad = 0, ready_bad = 0, pulse_bad = 0, count_bad = 0, trans_bad = 0;
  int sat_bad = 0, frames_seen = 0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      exp_q.delete();
      cur_frame  = '0;
      exp_pulse  = 1'b0;
      exp_count  = 8'd0;
      prev_bck   = 1'b0;
      prev_lrck  = 1'b0;
      prev_sdata = 1'b0;
    end else begin
      if (i2s_mclk !== ref_cnt[1] || i2s_bck !== ref_cnt[3] || i2s_lrck !== ref_cnt[9]) clk_bad++;
      full_old = (exp_q.size() != 0);
      if (in_ready !== !full_old) ready_bad++;
      if (underrun_pulse !== exp_pulse) pulse_bad++;
      if (underrun_count !== exp_count) count_bad++;
      if ((i2s_lrck !== prev_lrck || i2s_sdata !== prev_sdata) && !(prev_bck && !i2s_bck)) trans_bad++;
      prev_bck   = i2s_bck;
      prev_lrck  = i2s_lrck;
      prev_sdata = i2s_sdata;
      if (ref_cnt[3:0] == 4'd8) obs_frame[63 - ref_cnt[9:4]] = i2s_sdata;
      m_underrun = (ref_cnt == 10'h3FF) && !full_old;
      if (ref_cnt == 10'h3FF) begin
        check("frame", obs_frame, cur_frame);
        frames_seen++;
        cur_frame = full_old ? exp_q.pop_front() : '0;
      end
      exp_pulse = m_underrun;
      if (underrun_clr) exp_count = m_underrun ? 8'd1 : 8'd0;
      else if (m_underrun && exp_count != 8'hFF) exp_count = exp_count + 8'd1;
      if (in_valid && !full_old) exp_q.push_back(pat(in_left, in_right));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cnt(input logic [9:0] v);
    bit hit = 0;
    for (int i = 0; i < 2100 && !hit; i++) begin
      @(posedge sys_clk); #1;
      if (ref_cnt == v) hit = 1;
    end
    if (!hit) check("wait_cnt_timeout", ref_cnt, v);
  endtask

  task automatic wait_pulse(output int n);
    bit hit = 0;
    n = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge sys_clk); #1;
      n++;
      if (underrun_pulse) hit = 1;
    end
    if (!hit) check("pulse_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, output int t_acc);
    logic rdy;
    bit   done = 0;
    t_acc    = -1;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge sys_clk); rdy = in_ready;
      @(posedge sys_clk); #1;
      if (rdy) begin
        done  = 1;
        t_acc = cyc;
      end
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  function automatic logic pick_clk(input int sel);
    case (sel)
      0:       return i2s_mclk;
      1:       return i2s_bck;
      default: return i2s_lrck;
    endcase
  endfunction

  task automatic measure(input int sel, output int period, output int high);
    logic s, p;
    bit   found = 0;
    period = 0;
    high   = 0;
    @(negedge sys_clk); p = pick_clk(sel);
    for (int i = 0; i < 4096 && !found; i++) begin
      @(negedge sys_clk); s = pick_clk(sel);
      if (s && !p) found = 1;
      p = s;
    end
    if (!found) return;
    period = 1;
    high   = 1;
    for (int i = 0; i < 4096; i++) begin
      @(negedge sys_clk); s = pick_clk(sel);
      if (s && !p) break;
      period++;
      if (s) high++;
      p = s;
    end
  endtask

  // ---------------- main sequence ----------------
  task automatic main_seq();
    int n, t0, t1, t_prev, per, hi;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check("rst_ready", in_ready, 1);
    check("rst_count", underrun_count, 0);
    wait_pulse(n);
    check("first_boundary", n, 1024);
    check("first_underrun_count", underrun_count, 1);

    // Mid-frame reset while a data frame plays and another is held.
    send_frame(16'hFFFF, 16'hFFFF, t0);
    wait_cnt(10'd0);
    send_frame(16'hDEAD, 16'hBEEF, t0);
    check("held_not_ready", in_ready, 0);
    wait_cnt(10'd607);
    check("pre_rst_outputs", {i2s_mclk, i2s_bck, i2s_lrck, i2s_sdata}, 4'hF);
    check("pre_rst_count", underrun_count, 1);
    #1 sys_rst = 1'b1;
    #1;
    check("rst_clocks", {i2s_mclk, i2s_bck, i2s_lrck}, 3'b000);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_ready_async", in_ready, 1);
    check("rst_pulse", underrun_pulse, 0);
    check("rst_count_async", underrun_count, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    wait_pulse(n);
    check("restart_boundary", n, 1024);
    check("discard_underrun", underrun_count, 1);

    // Single frame, then back-to-back frames under backpressure.
    send_frame(16'hA5C3, 16'h1234, t_prev);
    for (int i = 0; i < 4; i++) begin
      send_frame(16'h8000 + 16'(i), 16'h7FF0 + 16'(i), t1);
      check($sformatf("bp_interval_%0d", i), t1 - t_prev, 1024);
      t_prev = t1;
    end
    check("bp_no_underrun", underrun_count, 1);

    wait_pulse(n);
    check("underrun_count_2", underrun_count, 2);
    @(posedge sys_clk); #1;
    check("pulse_width", underrun_pulse, 0);

    // Offer a frame exactly on the boundary cycle, with a clear on the same cycle.
    wait_cnt(10'h3FF);
    in_left      = 16'h5A5A;
    in_right     = 16'hC001;
    in_valid     = 1'b1;
    underrun_clr = 1'b1;
    check("coll_ready_before", in_ready, 1);
    @(posedge sys_clk); #1;
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    check("coll_accepted", in_ready, 0);
    check("coll_underrun", underrun_pulse, 1);
    check("clr_with_underrun", underrun_count, 1);
    wait_cnt(10'd0);
    check("ready_after_load", in_ready, 1);
    wait_cnt(10'd100);
    underrun_clr = 1'b1;
    @(posedge sys_clk); #1;
    underrun_clr = 1'b0;
    check("clr_count", underrun_count, 0);

    measure(0, per, hi);
    check("mclk_period", per, 4);
    check("mclk_high", hi, 2);
    measure(1, per, hi);
    check("bck_period", per, 16);
    check("bck_high", hi, 8);
    measure(2, per, hi);
    check("lrck_period", per, 1024);
    check("lrck_high", hi, 512);
  endtask

  task automatic sat_seq();
    int  exp_c;
    bit  seen;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_b = 1'b0;
    for (int i = 0; i < 270; i++) begin
      seen = 0;
      for (int j = 0; j < 300 && !seen; j++) begin
        @(posedge sys_clk); #1;
        if (b_pulse) seen = 1;
      end
      if (!seen) begin
        check("sat_timeout", 0, 1);
        break;
      end
      exp_c = (i + 1 > 255) ? 255 : i + 1;
      if (b_count !== 8'(exp_c)) sat_bad++;
      if (b_ready !== 1'b1 || b_sdata !== 1'b0 || {b_mclk, b_bck, b_lrck} !== 3'b000) sat_bad++;
      if (i == 0 || i == 254 || i == 269) check($sformatf("sat_count_%0d", i), b_count, exp_c);
    end
    b_clr = 1'b1;
    @(posedge sys_clk); #1;
    b_clr = 1'b0;
    check("sat_clr", b_count, 0);
  endtask

  initial begin
    sys_rst      = 1'b1;
    sys_rst_b    = 1'b1;
    in_valid     = 1'b0;
    in_left      = '0;
    in_right     = '0;
    underrun_clr = 1'b0;
    b_clr        = 1'b0;
    fork
      main_seq();
      sat_seq();
    join
    check("clock_phase_errs", clk_bad, 0);
    check("ready_errs", ready_bad, 0);
    check("pulse_errs", pulse_bad, 0);
    check("count_errs", count_bad, 0);
    check("transition_errs", trans_bad, 0);
    check("sat_errs", sat_bad, 0);
    check("frames_seen_enough", frames_seen > 10, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: reached cycle %0d, required finish before 95000", cyc);
    $fatal(1);
  end
endmodule
